// File: rtl/rs_decode_sched.sv
// rs_decode_sched: shares one single-error-correcting RS_Decoder between two requesters.
// Latency: grant to out_valid is 2 cycles; one codeword in flight, grants at least 3 cycles apart.
// Backpressure: the result holds while out_ready is low; no new grant until it is accepted.
// Optional feature macro: RS_SCHED_STATS_EN adds saturating per-requester correction counters.
// Field parameters `N and `SYMBOL_WIDTH come from GF.v; the defaults below match that field.

`ifndef SYMBOL_WIDTH
`define SYMBOL_WIDTH 3
`endif
`ifndef N
`define N 7
`endif

// RS(7,5) over GF(2^3), primitive polynomial x^3+x+1, corrects any single symbol error.
// The decoder is purely combinational; reset forces its output to zero.
module RS_Decoder (
  input  logic                             reset,
  input  logic [`N*`SYMBOL_WIDTH-1:0] codeword_in,
  output logic [`N*`SYMBOL_WIDTH-1:0] codeword_out
);
  localparam int SW = `SYMBOL_WIDTH;
  localparam int NS = `N;

  typedef logic [SW-1:0] sym_t;

  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t acc;
    sym_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SW; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[1], sh[0] ^ sh[2], sh[2]};
    end
    return acc;
  endfunction

  function automatic sym_t gf_exp(input logic [2:0] e);
    case (e)
      3'd0:    return 3'd1;
      3'd1:    return 3'd2;
      3'd2:    return 3'd4;
      3'd3:    return 3'd3;
      3'd4:    return 3'd6;
      3'd5:    return 3'd7;
      3'd6:    return 3'd5;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] gf_log(input sym_t a);
    case (a)
      3'd1:    return 3'd0;
      3'd2:    return 3'd1;
      3'd4:    return 3'd2;
      3'd3:    return 3'd3;
      3'd6:    return 3'd4;
      3'd7:    return 3'd5;
      3'd5:    return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  sym_t       s0;
  sym_t       s1;
  logic [2:0] log0;
  logic [2:0] log1;
  logic [2:0] loc;

  // Syndromes: S0 = sum r_i, S1 = sum r_i * alpha^i
  always_comb begin
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < NS; i++) begin
      s0 = s0 ^ codeword_in[i*SW +: SW];
      s1 = s1 ^ gf_mul(codeword_in[i*SW +: SW], gf_exp(3'(i)));
    end
  end

  // Single error: location = log(S1) - log(S0) mod 7, magnitude = S0; other patterns pass through
  always_comb begin
    codeword_out = codeword_in;
    log0 = gf_log(s0);
    log1 = gf_log(s1);
    loc  = (log1 < log0) ? (log1 - log0 + 3'd7) : (log1 - log0);
    if (reset) begin
      codeword_out = '0;
    end else if (s0 != '0 && s1 != '0) begin
      for (int i = 0; i < NS; i++) begin
        if (loc == 3'(i)) codeword_out[i*SW +: SW] = codeword_out[i*SW +: SW] ^ s0;
      end
    end
  end
endmodule

module rs_decode_sched #(
  parameter  int STAT_W = 16,
  localparam int CW_W   = `N * `SYMBOL_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CW_W-1:0]   req0_codeword,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CW_W-1:0]   req1_codeword,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_id,
  output logic [CW_W-1:0]   out_codeword,
  output logic              out_fixed,
  output logic              busy
`ifdef RS_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0] fix_count0,
  output logic [STAT_W-1:0] fix_count1
`endif
);
  typedef enum logic [1:0] {IDLE, DECODE, RESULT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant0;
  logic              grant1;
  logic              last;      // last-served requester; 1 means req0 wins the next tie
  logic              cap_id;
  logic [CW_W-1:0]   cap_cw;
  logic [CW_W-1:0]   dec_cw;

  RS_Decoder u_dec (
    .reset        (reset),
    .codeword_in  (cap_cw),
    .codeword_out (dec_cw)
  );

  // Next state and round-robin grant; grants only in IDLE and never while reset is asserted
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        if (!reset) begin
          if (req0_valid && req1_valid) begin
            if (last) grant0 = 1'b1;
            else      grant1 = 1'b1;
          end else if (req0_valid) begin
            grant0 = 1'b1;
          end else if (req1_valid) begin
            grant1 = 1'b1;
          end
        end
        if (grant0 || grant1) state_nxt = DECODE;
      end
      DECODE:  state_nxt = RESULT;
      RESULT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign out_valid  = (state == RESULT);
  assign busy       = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Capture the granted codeword and owner, and advance the round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_cw <= '0;
      cap_id <= 1'b0;
      last   <= 1'b1;
    end else if (grant0 || grant1) begin
      cap_cw <= grant1 ? req1_codeword : req0_codeword;
      cap_id <= grant1;
      last   <= grant1;
    end
  end

  // Register the decoder result at the end of DECODE; it then holds through RESULT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_codeword <= '0;
      out_fixed    <= 1'b0;
      out_id       <= 1'b0;
    end else if (state == DECODE) begin
      out_codeword <= dec_cw;
      out_fixed    <= (dec_cw != cap_cw);
      out_id       <= cap_id;
    end
  end

`ifdef RS_SCHED_STATS_EN
  // Count accepted corrected results per owner, saturating at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fix_count0 <= '0;
      fix_count1 <= '0;
    end else if (out_valid && out_ready && out_fixed) begin
      if (!out_id && fix_count0 != '1) fix_count0 <= fix_count0 + 1'b1;
      if (out_id && fix_count1 != '1)  fix_count1 <= fix_count1 + 1'b1;
    end
  end
`else
  logic unused_stat_w;
  assign unused_stat_w = (STAT_W > 0);
`endif
endmodule

// File: doc/rs_decode_sched.md
RS_DECODE_SCHED -- requirements
Module: rs_decode_sched

Interface
REQ-001 SHALL take `N` (symbols per codeword) and `SYMBOL_WIDTH` (bits per symbol) from GF.v; CW_W = `N*`SYMBOL_WIDTH.
REQ-002 SHALL have parameter STAT_W, default 16, the width of each correction counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has a codeword to decode.
REQ-006 req0_ready  output  1  requester 0 codeword accepted this cycle.
REQ-007 req0_codeword  input  CW_W  requester 0 received codeword.
REQ-008 req1_valid / req1_ready / req1_codeword  same widths and meaning as REQ-005..007, for requester 1.
REQ-009 out_valid  output  1  decoded result is available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out_id  output  1  index of the requester that owns the result.
REQ-012 out_codeword  output  CW_W  corrected codeword.
REQ-013 out_fixed  output  1  corrected codeword differs from the received codeword.
REQ-014 busy  output  1  state is not IDLE.
REQ-015 fix_count0 / fix_count1  output  STAT_W each  corrections per requester; present only with RS_SCHED_STATS_EN.

Function
REQ-016 SHALL instantiate exactly one RS_Decoder, with its reset input tied to reset and its codeword input driven from an internal capture register cap_cw.
REQ-017 SHALL implement three states:
- IDLE -> DECODE when a grant is issued.
- DECODE -> RESULT unconditionally after one cycle.
- RESULT -> IDLE on out_valid && out_ready.
REQ-018 Grant rule: a grant is issued only in IDLE, to at most one requester per cycle.
- reqN_ready is high only in the grant cycle, combinationally from reqN_valid and the arbiter.
- cap_cw and the owner id are captured on the grant edge.
REQ-019 Arbitration SHALL be round-robin with a last-served pointer.
- When both are valid, the requester other than last-served wins.
- The pointer updates on each grant.
- The pointer resets to 1, so req0 wins the first tie.
REQ-020 On the DECODE edge, SHALL register:
- the decoder output into out_codeword;
- (corrected != cap_cw) into out_fixed;
- the owner into out_id.
REQ-021 out_valid SHALL be high exactly in RESULT.
- Grant to out_valid latency is 2 cycles.
- Minimum spacing between grants is 3 cycles.
REQ-022 While out_valid && !out_ready, out_codeword, out_fixed and out_id SHALL hold stable, and no grant is issued.
REQ-023 No new grant SHALL be issued in the cycle a result is accepted; the next grant can occur in the following IDLE cycle.
- A requester whose valid is low SHALL never be granted.
- A requester may drop valid before its grant without penalty.

Reset
REQ-024 While reset is high, SHALL force the following, asynchronously:
- state = IDLE; pointer = 1;
- out_valid = 0, out_id = 0, out_codeword = 0, out_fixed = 0;
- busy = 0, req0_ready = 0, req1_ready = 0;
- cap_cw = 0; fix counters = 0.
REQ-025 Reset asserted in DECODE or RESULT SHALL discard the in-flight codeword with no output handshake; the first grant after deassertion follows REQ-019.

Configuration
REQ-026 Macro RS_SCHED_STATS_EN defined: fix_countN SHALL increment by 1 when a result owned by requester N with out_fixed = 1 is accepted (out_valid && out_ready), saturating at 2^STAT_W-1.
REQ-027 Macro RS_SCHED_STATS_EN undefined: the fix_count ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-028 After reset, req0_valid=1 with all-zero codeword, out_ready=1 -> req0_ready pulses at cycle 0; out_valid at cycle 2 with out_codeword=0, out_fixed=0, out_id=0.
REQ-029 After reset, req0_valid and req1_valid both held 1 -> grants go req0, req1, req0, req1 across four consecutive transactions; out_id sequence 0,1,0,1.
REQ-030 Valid codeword with symbol 3 XORed by 1 on req1 -> out_codeword equals the original codeword, out_fixed=1, out_id=1; with the macro, fix_count1 becomes 1 on the handshake.
REQ-031 out_ready held 0 for 5 cycles in RESULT with both requesters valid -> outputs stable, both readys 0, busy=1; out_ready=1 -> IDLE the next cycle, grant the cycle after.
REQ-032 Reset pulsed during DECODE -> out_valid never rises for that codeword; all outputs read 0 within the reset cycle; next req0 request completes normally.
REQ-033 Macro defined, STAT_W=2, five corrected req0 results accepted -> fix_count0 reads 1,2,3,3,3; fix_count1 stays 0.
